// File: rtl/ifd_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : ifd_fetch_unit
// Brief    : Fetch/decode front end. Issues single-outstanding instruction
//            memory reads, presents fetched instructions with NPC and source
//            register addresses, and inserts bubbles for memory wait,
//            load-use hazards and EX-resolved redirects.
// Revision : 1.0 - initial release
// ============================================================================
module ifd_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic [31:0] IFD_NPC,
  output logic [31:0] IFD_IR,
  output logic [4:0]  IFD_RS1_Addr_In,
  output logic [4:0]  IFD_RS2_Addr_In,
  output logic        stall
);

  localparam logic [6:0] c_OPC_LOAD = 7'b0000011;

  // FETCH: ready to issue; WAIT: one read in flight;
  // HOLD: hazard-delayed instruction parked; DRAIN: squashed read in flight.
  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_hold_ir;
  logic [31:0] w_hold_nxt;

  logic [31:0] w_pc_inc;
  logic [31:0] w_target;
  logic        w_ex_is_load;
  logic [4:0]  w_ex_rd;
  logic        w_hazard;

  logic        w_present;
  logic [31:0] w_new_ir;
  logic [31:0] w_new_npc;

  assign w_pc_inc = r_pc + 32'd4;
  // Low two bits of the redirect target are ignored so the PC stays aligned.
  assign w_target = ex_target & ~32'd3;

  // The instruction now sitting in IFD_IR is the one executing in EX.
  assign w_ex_is_load = (IFD_IR[6:0] == c_OPC_LOAD);
  assign w_ex_rd      = IFD_IR[11:7];
  // Conservative check: rs fields are compared regardless of the incoming opcode.
  assign w_hazard     = w_ex_is_load && (w_ex_rd != 5'd0) &&
                        ((w_ex_rd == imem_rdata[19:15]) ||
                         (w_ex_rd == imem_rdata[24:20]));

  // State, PC and hold buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_hold_ir <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_hold_ir <= w_hold_nxt;
    end
  end

  // Next-state, PC update, memory request and presentation decision.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_nxt  = r_hold_ir;
    imem_req    = 1'b0;
    imem_addr   = r_pc;
    w_present   = 1'b0;
    w_new_ir    = NOP_INSN;
    w_new_npc   = 32'd0;

    case (r_state)
      ST_FETCH: begin
        if (ex_redirect) begin
          w_pc_nxt = w_target;
        end else begin
          imem_req    = 1'b1;
          imem_addr   = r_pc;
          w_state_nxt = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (imem_rvalid) begin
          if (ex_redirect) begin
            // Response belongs to the wrong path: drop it.
            w_pc_nxt    = w_target;
            w_state_nxt = ST_FETCH;
          end else if (w_hazard) begin
            // Park the word for one cycle so the load result can be forwarded.
            w_hold_nxt  = imem_rdata;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = ST_HOLD;
          end else begin
            // Present and immediately chain the next sequential read.
            w_present   = 1'b1;
            w_new_ir    = imem_rdata;
            w_new_npc   = w_pc_inc;
            w_pc_nxt    = w_pc_inc;
            imem_req    = 1'b1;
            imem_addr   = w_pc_inc;
          end
        end else if (ex_redirect) begin
          // The outstanding read must still be absorbed before refetching.
          w_pc_nxt    = w_target;
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_HOLD: begin
        if (ex_redirect) begin
          w_pc_nxt    = w_target;
          w_state_nxt = ST_FETCH;
        end else begin
          // PC was already advanced past the held instruction.
          w_present   = 1'b1;
          w_new_ir    = r_hold_ir;
          w_new_npc   = r_pc;
          imem_req    = 1'b1;
          imem_addr   = r_pc;
          w_state_nxt = ST_WAIT;
        end
      end

      ST_DRAIN: begin
        if (ex_redirect) begin
          w_pc_nxt = w_target;
        end
        if (imem_rvalid) begin
          w_state_nxt = ST_FETCH;
        end
      end

      default: begin
        w_state_nxt = ST_FETCH;
      end
    endcase
  end

  // Output register: a new instruction or a bubble every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IFD_IR          <= NOP_INSN;
      IFD_NPC         <= 32'd0;
      IFD_RS1_Addr_In <= 5'd0;
      IFD_RS2_Addr_In <= 5'd0;
      stall           <= 1'b1;
    end else if (w_present) begin
      IFD_IR          <= w_new_ir;
      IFD_NPC         <= w_new_npc;
      IFD_RS1_Addr_In <= w_new_ir[19:15];
      IFD_RS2_Addr_In <= w_new_ir[24:20];
      stall           <= 1'b0;
    end else begin
      IFD_IR          <= NOP_INSN;
      IFD_NPC         <= 32'd0;
      IFD_RS1_Addr_In <= 5'd0;
      IFD_RS2_Addr_In <= 5'd0;
      stall           <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ifd_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifd_fetch_unit
// Brief    : Self-checking bench for ifd_fetch_unit: directed vector table
//            plus randomized memory/redirect traffic against a stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifd_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic [31:0] IFD_NPC;
  logic [31:0] IFD_IR;
  logic [4:0]  IFD_RS1_Addr_In;
  logic [4:0]  IFD_RS2_Addr_In;
  logic        stall;

  ifd_fetch_unit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .ex_redirect     (ex_redirect),
    .ex_target       (ex_target),
    .IFD_NPC         (IFD_NPC),
    .IFD_IR          (IFD_IR),
    .IFD_RS1_Addr_In (IFD_RS1_Addr_In),
    .IFD_RS2_Addr_In (IFD_RS2_Addr_In),
    .stall           (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Load-use rule: ld is a load with nonzero rd read by nx as rs1 or rs2.
  function automatic bit hz(input logic [31:0] ld, input logic [31:0] nx);
    return (ld[6:0] == 7'b0000011) && (ld[11:7] != 5'd0) &&
           ((ld[11:7] == nx[19:15]) || (ld[11:7] == nx[24:20]));
  endfunction

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rv;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] tgt;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [31:0] exp_ir;
    logic [31:0] exp_npc;
    logic        exp_stall;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] rdata,
                              input logic redir, input logic [31:0] tgt,
                              input logic req, input logic [31:0] addr,
                              input logic [31:0] ir, input logic [31:0] npc,
                              input logic st);
    vec_t v;
    v.rv = rv; v.rdata = rdata; v.redir = redir; v.tgt = tgt;
    v.exp_req = req; v.exp_addr = addr;
    v.exp_ir = ir; v.exp_npc = npc; v.exp_stall = st;
    return v;
  endfunction

  vec_t tbl[24];

  task automatic apply_vec(input int idx, input vec_t v);
    logic [4:0] ers1, ers2;
    @(negedge clk);
    imem_rvalid = v.rv;
    imem_rdata  = v.rdata;
    ex_redirect = v.redir;
    ex_target   = v.tgt;
    #1;
    chk($sformatf("v%0d_req", idx), {31'd0, imem_req}, {31'd0, v.exp_req});
    if (v.exp_req) chk($sformatf("v%0d_addr", idx), imem_addr, v.exp_addr);
    @(posedge clk);
    #1;
    ers1 = v.exp_stall ? 5'd0 : v.exp_ir[19:15];
    ers2 = v.exp_stall ? 5'd0 : v.exp_ir[24:20];
    chk($sformatf("v%0d_ir", idx),    IFD_IR,  v.exp_ir);
    chk($sformatf("v%0d_npc", idx),   IFD_NPC, v.exp_npc);
    chk($sformatf("v%0d_stall", idx), {31'd0, stall}, {31'd0, v.exp_stall});
    chk($sformatf("v%0d_rs1", idx),   {27'd0, IFD_RS1_Addr_In}, {27'd0, ers1});
    chk($sformatf("v%0d_rs2", idx),   {27'd0, IFD_RS2_Addr_In}, {27'd0, ers2});
  endtask

  // ---------------- randomized environment + model ----------------
  logic [31:0] mem [64];
  int          cyc;
  bit          pend;
  int          due;
  logic [31:0] paddr;
  logic [31:0] exp_req_addr;
  logic [31:0] exp_pc;
  logic [31:0] last_word;
  bit          last_present;
  bit          have_prev;
  int          gap;
  int          idle;
  int          npresented;

  function automatic logic [31:0] rand_insn();
    logic [4:0] rd, rs1, rs2;
    rd  = 5'($urandom_range(0, 7));
    rs1 = 5'($urandom_range(0, 7));
    rs2 = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 2))
      0:       return {12'($urandom), rs1, 3'b010, rd, 7'b0000011};
      1:       return {7'd0, rs2, rs1, 3'b000, rd, 7'b0110011};
      default: return {12'($urandom), rs1, 3'b000, rd, 7'b0010011};
    endcase
  endfunction

  task automatic model_reset();
    pend = 0; cyc = 0; due = 0; paddr = 0;
    exp_req_addr = 32'h0; exp_pc = 32'h0;
    last_word = NOP; last_present = 0; have_prev = 0; gap = 0; idle = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ex_redirect = 1'b0; ex_target = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic rnd_cycle(input int lat_max, input int redir_pct, input bit gap_exact);
    bit          rv, redir, req;
    logic [31:0] tgt, addr, ew;
    @(negedge clk);
    rv    = pend && (cyc == due);
    redir = ($urandom_range(0, 99) < redir_pct);
    tgt   = $urandom;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem[paddr[7:2]] : $urandom;
    ex_redirect = redir;
    ex_target   = tgt;
    #1;
    req  = imem_req;
    addr = imem_addr;
    if (rv) pend = 0;
    if (req) begin
      chk("req_addr", addr, exp_req_addr);
      chk("req_while_outstanding", {31'd0, pend}, 32'd0);
      chk("req_with_redirect", {31'd0, redir}, 32'd0);
      exp_req_addr = addr + 32'd4;
      pend  = 1;
      paddr = addr;
      due   = cyc + $urandom_range(1, lat_max);
      idle  = 0;
    end else if (!pend && !redir) begin
      idle++;
      if (idle > 8) begin
        chk("fetch_progress_idle", idle, 32'd0);
        idle = 0;
      end
    end
    if (redir) exp_req_addr = tgt & ~32'd3;
    @(posedge clk);
    #1;
    cyc++;
    if (redir) begin
      chk("redirect_bubble", {31'd0, stall}, 32'd1);
      exp_pc    = tgt & ~32'd3;
      have_prev = 0;
      gap       = 0;
    end
    if (stall) begin
      if (!redir) begin
        chk("bubble_ir", IFD_IR, NOP);
        chk("bubble_fields", {IFD_NPC[26:0], IFD_RS1_Addr_In}, 32'd0);
        chk("bubble_rs2", {27'd0, IFD_RS2_Addr_In}, 32'd0);
      end
      gap++;
      last_present = 0;
    end else begin
      ew = mem[exp_pc[7:2]];
      chk("stream_ir", IFD_IR, ew);
      chk("stream_npc", IFD_NPC, exp_pc + 32'd4);
      chk("stream_rs", {22'd0, IFD_RS1_Addr_In, IFD_RS2_Addr_In},
          {22'd0, ew[19:15], ew[24:20]});
      chk("hazard_not_bubbled", {31'd0, last_present && hz(last_word, ew)}, 32'd0);
      if (gap_exact && have_prev)
        chk("bubble_count", gap, hz(last_word, ew) ? 32'd1 : 32'd0);
      have_prev    = 1;
      gap          = 0;
      exp_pc       = exp_pc + 32'd4;
      last_word    = ew;
      last_present = 1;
      npresented++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b1;
    ex_redirect = 1'b0; ex_target = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    npresented = 0;
    model_reset();
    #1 rst_n = 1'b0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ir", IFD_IR, NOP);
    chk("reset_npc", IFD_NPC, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd1);
    chk("reset_rs1", {27'd0, IFD_RS1_Addr_In}, 32'd0);
    chk("reset_rs2", {27'd0, IFD_RS2_Addr_In}, 32'd0);
    #1 rst_n = 1'b1;

    //            rv  rdata          rd  tgt           req addr          ir             npc           st
    tbl[0]  = mk(0, 32'h0,          0, 32'h0,         1, 32'h0,         NOP,           32'h0,        1);
    tbl[1]  = mk(1, 32'h00500093,   0, 32'h0,         1, 32'h4,         32'h00500093,  32'h4,        0);
    tbl[2]  = mk(1, 32'h00100113,   0, 32'h0,         1, 32'h8,         32'h00100113,  32'h8,        0);
    tbl[3]  = mk(1, 32'h0000A283,   0, 32'h0,         1, 32'hC,         32'h0000A283,  32'hC,        0);
    tbl[4]  = mk(1, 32'h00228333,   0, 32'h0,         0, 32'h0,         NOP,           32'h0,        1);
    tbl[5]  = mk(0, 32'h0,          0, 32'h0,         1, 32'h10,        32'h00228333,  32'h10,       0);
    tbl[6]  = mk(1, 32'h0000A003,   0, 32'h0,         1, 32'h14,        32'h0000A003,  32'h14,       0);
    tbl[7]  = mk(1, 32'h00000033,   0, 32'h0,         1, 32'h18,        32'h00000033,  32'h18,       0);
    tbl[8]  = mk(0, 32'h0,          1, 32'h100,       0, 32'h0,         NOP,           32'h0,        1);
    tbl[9]  = mk(0, 32'h0,          0, 32'h0,         0, 32'h0,         NOP,           32'h0,        1);
    tbl[10] = mk(1, 32'h00700393,   0, 32'h0,         0, 32'h0,         NOP,           32'h0,        1);
    tbl[11] = mk(0, 32'h0,          0, 32'h0,         1, 32'h100,       NOP,           32'h0,        1);
    tbl[12] = mk(0, 32'h0,          0, 32'h0,         0, 32'h0,         NOP,           32'h0,        1);
    tbl[13] = mk(0, 32'h0,          0, 32'h0,         0, 32'h0,         NOP,           32'h0,        1);
    tbl[14] = mk(1, 32'h00400213,   0, 32'h0,         1, 32'h104,       32'h00400213,  32'h104,      0);
    tbl[15] = mk(0, 32'h0,          0, 32'h0,         0, 32'h0,         NOP,           32'h0,        1);
    tbl[16] = mk(0, 32'h0,          0, 32'h0,         0, 32'h0,         NOP,           32'h0,        1);
    tbl[17] = mk(1, 32'h00500293,   1, 32'hFFFFFFFE,  0, 32'h0,         NOP,           32'h0,        1);
    tbl[18] = mk(0, 32'h0,          0, 32'h0,         1, 32'hFFFFFFFC,  NOP,           32'h0,        1);
    tbl[19] = mk(1, 32'h00100093,   0, 32'h0,         1, 32'h0,         32'h00100093,  32'h0,        0);
    tbl[20] = mk(1, 32'h00200113,   0, 32'h0,         1, 32'h4,         32'h00200113,  32'h4,        0);
    tbl[21] = mk(0, 32'h0,          0, 32'h0,         0, 32'h0,         NOP,           32'h0,        1);
    tbl[22] = mk(1, 32'h00300193,   1, 32'h40,        0, 32'h0,         NOP,           32'h0,        1);
    tbl[23] = mk(0, 32'h0,          0, 32'h0,         1, 32'h40,        NOP,           32'h0,        1);

    foreach (tbl[i]) apply_vec(i, tbl[i]);

    // Randomized program image with frequent register collisions.
    foreach (mem[i]) mem[i] = rand_insn();

    // Phase A: 1-cycle memory, no redirects: bubbles only for load-use.
    do_reset();
    for (int i = 0; i < 400; i++) rnd_cycle(1, 0, 1'b1);

    // Asynchronous reset in the middle of operation takes effect at once.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_ir", IFD_IR, NOP);
    chk("async_reset_stall", {31'd0, stall}, 32'd1);
    chk("async_reset_npc", IFD_NPC, 32'd0);

    // Phase B: variable latency with redirects.
    do_reset();
    for (int i = 0; i < 1500; i++) rnd_cycle(3, 8, 1'b0);

    // Phase C: fast memory, frequent redirects (hits HOLD+redirect).
    do_reset();
    for (int i = 0; i < 800; i++) rnd_cycle(1, 15, 1'b0);

    chk("instructions_presented", {31'd0, npresented > 600}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
